// File: rtl/line_text_streamer_if.sv
// Bus bundle for line_text_streamer: line request, descriptor and char-memory reads, char stream.
// master = streamer side, slave = environment (request source, memories, glyph stage).
interface line_text_streamer_if #(
    parameter int unsigned CHAR_W         = 8,
    parameter int unsigned CHARS_PER_WORD = 2,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned LEN_W          = 10,
    parameter int unsigned LINE_W         = 8
);
    logic                             req_valid;
    logic [LINE_W-1:0]                req_line;
    logic                             req_ready;
    logic [LINE_W-1:0]                desc_addr;
    logic [LEN_W+ADDR_W-1:0]          desc_data;
    logic [ADDR_W-1:0]                mem_addr;
    logic [CHAR_W*CHARS_PER_WORD-1:0] mem_data;
    logic                             char_valid;
    logic                             char_ready;
    logic [CHAR_W-1:0]                char_data;
    logic                             char_last;
    logic                             line_done;

    modport master (
        input  req_valid, req_line, desc_data, mem_data, char_ready,
        output req_ready, desc_addr, mem_addr, char_valid, char_data, char_last, line_done
    );

    modport slave (
        output req_valid, req_line, desc_data, mem_data, char_ready,
        input  req_ready, desc_addr, mem_addr, char_valid, char_data, char_last, line_done
    );
endinterface

// File: rtl/line_text_streamer.sv
// Streams one text line, char by char, from a descriptor table and packed char memory.
// Optional fixed-width padding/truncation is enabled by defining LTS_PAD_EN.
module line_text_streamer #(
    parameter int unsigned       CHAR_W         = 8,
    parameter int unsigned       CHARS_PER_WORD = 2,
    parameter int unsigned       ADDR_W         = 10,
    parameter int unsigned       LEN_W          = 10,
    parameter int unsigned       LINE_W         = 8,
    parameter int unsigned       LINE_CHARS     = 40,
    parameter logic [CHAR_W-1:0] PAD_CHAR       = 8'h20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    line_text_streamer_if.master bus_io
);
`ifdef LTS_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int unsigned WORD_W = CHAR_W * CHARS_PER_WORD;
    localparam int unsigned IDX_W  = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
    localparam int unsigned LC_W   = $clog2(LINE_CHARS + 1);
    localparam int unsigned CNT_W  = (LEN_W > LC_W) ? LEN_W : LC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_LOAD,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   desc_addr_q, desc_addr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;

    logic [LEN_W-1:0]    desc_len;
    logic [ADDR_W-1:0]   desc_start;
    logic [CNT_W-1:0]    eff_len;
    logic [CNT_W-1:0]    total;
    logic [CHAR_W-1:0]   cur_char;
    logic                is_last;
    logic                padding;
    logic                next_pad;
    logic                more_words;
    logic                idx_end;

    assign desc_len   = bus_io.desc_data[LEN_W+ADDR_W-1:ADDR_W];
    assign desc_start = bus_io.desc_data[ADDR_W-1:0];

    always_comb begin
        eff_len = CNT_W'(desc_len);
        if (PAD_EN && (CNT_W'(desc_len) > CNT_W'(LINE_CHARS))) begin
            eff_len = CNT_W'(LINE_CHARS);
        end
    end

    assign total      = PAD_EN ? CNT_W'(LINE_CHARS) : len_q;
    assign is_last    = (cnt_q == (total - CNT_W'(1)));
    assign padding    = PAD_EN && (cnt_q >= len_q);
    assign next_pad   = PAD_EN && ((cnt_q + CNT_W'(1)) >= len_q);
    assign more_words = (len_q - cnt_q) > CNT_W'(CHARS_PER_WORD);
    assign idx_end    = (idx_q == IDX_W'(CHARS_PER_WORD - 1));

    always_comb begin
        cur_char = '0;
        for (int unsigned i = 0; i < CHARS_PER_WORD; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_char = word_q[WORD_W-1-i*CHAR_W -: CHAR_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            desc_addr_q <= '0;
            mem_addr_q  <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            desc_addr_q <= desc_addr_d;
            mem_addr_q  <= mem_addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
        end
    end

    // The next word address is issued as soon as the current word is latched, so the
    // one-cycle read latency is hidden behind EMIT and FETCH always sees valid data.
    always_comb begin
        state_d     = state_q;
        desc_addr_d = desc_addr_q;
        mem_addr_d  = mem_addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        word_d      = word_q;
        case (state_q)
            S_IDLE: begin
                if (bus_io.req_valid) begin
                    desc_addr_d = bus_io.req_line;
                    state_d     = S_DESC;
                end
            end
            S_DESC: state_d = S_LOAD;
            S_LOAD: begin
                len_d      = eff_len;
                cnt_d      = '0;
                idx_d      = '0;
                mem_addr_d = desc_start;
                if (eff_len == '0) begin
                    state_d = PAD_EN ? S_EMIT : S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                word_d = bus_io.mem_data;
                idx_d  = '0;
                if (more_words) begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (bus_io.char_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (!next_pad) begin
                            if (idx_end) begin
                                state_d = S_FETCH;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // LOAD presents the start address straight from the table so the first word is ready in FETCH.
    assign bus_io.req_ready  = (state_q == S_IDLE);
    assign bus_io.desc_addr  = desc_addr_q;
    assign bus_io.mem_addr   = (state_q == S_LOAD) ? desc_start : mem_addr_q;
    assign bus_io.char_valid = (state_q == S_EMIT);
    assign bus_io.char_data  = ((state_q == S_EMIT) && padding) ? PAD_CHAR : cur_char;
    assign bus_io.char_last  = (state_q == S_EMIT) && is_last;
    assign bus_io.line_done  = (state_q == S_DONE);
endmodule
